// File: rtl/mips_dbg_pkg.sv
// Shared encodings for the MIPS program loader / run controller.
// Holds the controller state enum and the halt-reason codes it reports.
package mips_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    HR_NONE     = 2'd0,
    HR_LIMIT    = 2'd1,
    HR_HALT_PC  = 2'd2,
    HR_OVERFLOW = 2'd3
  } halt_reason_e;

endpackage

// File: rtl/mips_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Used for the run-cycle count so a very long run never reads back as a short one.
module mips_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mips_prog_loader_ctrl.sv
// Loads a program into instruction memory over valid/ready, holds the core in reset,
// runs it until a cycle limit or halt PC, then freezes it and reports why it stopped.
module mips_prog_loader_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int IMEM_DEPTH = 16,
  parameter int ADDR_W     = 4,
  parameter int PC_W       = 32,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  input  logic [CNT_W-1:0]  run_limit,
  input  logic              halt_en,
  input  logic [PC_W-1:0]   halt_pc,
  input  logic [PC_W-1:0]   core_pc,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              core_run,
  output logic              done,
  output logic [1:0]        halt_reason,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int WL_W   = ADDR_W + 1;
  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_e            state_q, state_d;
  halt_reason_e      halt_reason_q, halt_reason_d;
  logic              ld_ready_q, ld_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              core_reset_q, core_reset_d;
  logic              core_run_q, core_run_d;
  logic              done_q, done_d;
  logic [WL_W-1:0]   words_loaded_q, words_loaded_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic              accept;
  logic              wl_full;
  logic              hit_pc;
  logic              hit_limit;
  logic              cnt_clear;
  logic              cnt_inc;
  logic [CNT_W:0]    cnt_plus1;

  mips_sat_counter #(
    .W(CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .count (cycle_count)
  );

  assign accept    = ld_valid && ld_ready_q && (state_q == ST_LOAD);
  assign wl_full   = (words_loaded_q == WL_W'(IMEM_DEPTH));
  assign hit_pc    = halt_en && (core_pc == halt_pc);
  // Widened by one bit so a saturated count can never alias onto run_limit.
  assign cnt_plus1 = {1'b0, cycle_count} + {{CNT_W{1'b0}}, 1'b1};
  assign hit_limit = (run_limit != '0) && (cnt_plus1 == {1'b0, run_limit});
  assign cnt_inc   = (state_q == ST_RUN);

  always_comb begin
    state_d        = state_q;
    halt_reason_d  = halt_reason_q;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    words_loaded_d = words_loaded_q;
    hold_cnt_d     = hold_cnt_q;
    cnt_clear      = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d        = ST_LOAD;
            words_loaded_d = '0;
            halt_reason_d  = HR_NONE;
            cnt_clear      = 1'b1;
          end
        end
        ST_LOAD: begin
          // A word beyond the last imem slot is dropped rather than wrapping onto word 0.
          if (accept) begin
            if (wl_full) begin
              state_d       = ST_DONE;
              halt_reason_d = HR_OVERFLOW;
            end else begin
              imem_we_d      = 1'b1;
              imem_addr_d    = words_loaded_q[ADDR_W-1:0];
              imem_wdata_d   = ld_data;
              words_loaded_d = words_loaded_q + WL_W'(1);
              if (ld_last) begin
                state_d    = ST_HOLD;
                hold_cnt_d = '0;
              end
            end
          end
        end
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_W'(RST_CYCLES - 1)) begin
            state_d = ST_RUN;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          if (hit_pc) begin
            state_d       = ST_DONE;
            halt_reason_d = HR_HALT_PC;
          end else if (hit_limit) begin
            state_d       = ST_DONE;
            halt_reason_d = HR_LIMIT;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    ld_ready_d   = (state_d == ST_LOAD);
    core_reset_d = (state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_HOLD);
    core_run_d   = (state_d == ST_RUN);
    done_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      halt_reason_q  <= HR_NONE;
      ld_ready_q     <= 1'b0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      core_reset_q   <= 1'b1;
      core_run_q     <= 1'b0;
      done_q         <= 1'b0;
      words_loaded_q <= '0;
      hold_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      halt_reason_q  <= halt_reason_d;
      ld_ready_q     <= ld_ready_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      core_reset_q   <= core_reset_d;
      core_run_q     <= core_run_d;
      done_q         <= done_d;
      words_loaded_q <= words_loaded_d;
      hold_cnt_q     <= hold_cnt_d;
    end
  end

  assign ld_ready     = ld_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign core_reset   = core_reset_q;
  assign core_run     = core_run_q;
  assign done         = done_q;
  assign halt_reason  = halt_reason_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_mips_prog_loader_ctrl.sv
// Directed bench for the program loader: a per-cycle vector table plus hand sequences
// for load/run/halt, overflow, reset and abort, with a tiny PC model standing in for the core.
module tb_mips_prog_loader_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic [15:0] run_limit = '0;
  logic        halt_en = 1'b0;
  logic [31:0] halt_pc = '0;
  logic [31:0] core_pc;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        core_run;
  logic        done;
  logic [1:0]  halt_reason;
  logic [15:0] cycle_count;
  logic [4:0]  words_loaded;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [16];
  int          wr_count = 0;

  mips_prog_loader_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .run_limit    (run_limit),
    .halt_en      (halt_en),
    .halt_pc      (halt_pc),
    .core_pc      (core_pc),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_reset   (core_reset),
    .core_run     (core_run),
    .done         (done),
    .halt_reason  (halt_reason),
    .cycle_count  (cycle_count),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Stand-in core: PC sits at 0 in reset and advances one word per enabled cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) core_pc <= '0;
    else if (core_reset) core_pc <= '0;
    else if (core_run) core_pc <= core_pc + 32'd4;
  end

  always @(posedge clk) begin
    if (imem_we) begin
      mem[imem_addr] <= imem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  typedef struct {
    logic        start;
    logic        abort;
    logic        ld_valid;
    logic        ld_last;
    logic [31:0] ld_data;
    logic [63:0] exp;
  } vec_t;

  function automatic logic [63:0] mk_exp(input logic rdy, input logic we, input logic [3:0] addr,
                                         input logic [31:0] wdata, input logic crst, input logic crun,
                                         input logic dn, input logic [1:0] hr, input logic [15:0] cc,
                                         input logic [4:0] wl);
    return {rdy, we, addr, wdata, crst, crun, dn, hr, cc, wl};
  endfunction

  function automatic logic [63:0] dut_out();
    return {ld_ready, imem_we, imem_addr, imem_wdata, core_reset, core_run, done,
            halt_reason, cycle_count, words_loaded};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    start = v.start;
    abort = v.abort;
    ld_valid = v.ld_valid;
    ld_last = v.ld_last;
    ld_data = v.ld_data;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    ld_valid = 1'b0;
    ld_last = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] d, input logic last);
    int guard = 0;
    ld_valid = 1'b1;
    ld_data = d;
    ld_last = last;
    while (!ld_ready && guard < 20) begin
      tick(1);
      guard++;
    end
    if (!ld_ready) checkOutput("ld_ready_timeout", 64'd0, 64'd1);
    tick(1);
    ld_valid = 1'b0;
    ld_last = 1'b0;
  endtask

  task automatic waitDone();
    int guard = 0;
    while (!done && guard < 200) begin
      tick(1);
      guard++;
    end
    checkOutput("done_reached", {63'd0, done}, 64'd1);
  endtask

  logic [31:0] prog [6];
  vec_t        vecs [14];
  int          wr_base;

  initial begin
    prog[0] = 32'h012A8020; prog[1] = 32'hAE100010; prog[2] = 32'h8E110010;
    prog[3] = 32'h12300002; prog[4] = 32'h00000000; prog[5] = 32'h0800000A;

    vecs[0]  = '{1, 0, 0, 0, 32'h0, mk_exp(1, 0, 4'd0, 32'h0, 1, 0, 0, 2'd0, 16'd0, 5'd0)};
    vecs[1]  = '{0, 0, 1, 0, 32'hA1, mk_exp(1, 1, 4'd0, 32'hA1, 1, 0, 0, 2'd0, 16'd0, 5'd1)};
    vecs[2]  = '{0, 0, 0, 0, 32'h0, mk_exp(1, 0, 4'd0, 32'hA1, 1, 0, 0, 2'd0, 16'd0, 5'd1)};
    vecs[3]  = '{0, 0, 1, 1, 32'hB2, mk_exp(0, 1, 4'd1, 32'hB2, 1, 0, 0, 2'd0, 16'd0, 5'd2)};
    vecs[4]  = '{0, 0, 0, 0, 32'h0, mk_exp(0, 0, 4'd1, 32'hB2, 1, 0, 0, 2'd0, 16'd0, 5'd2)};
    vecs[5]  = '{0, 0, 0, 0, 32'h0, mk_exp(0, 0, 4'd1, 32'hB2, 0, 1, 0, 2'd0, 16'd0, 5'd2)};
    vecs[6]  = '{0, 0, 0, 0, 32'h0, mk_exp(0, 0, 4'd1, 32'hB2, 0, 1, 0, 2'd0, 16'd1, 5'd2)};
    vecs[7]  = '{1, 0, 0, 0, 32'h0, mk_exp(0, 0, 4'd1, 32'hB2, 0, 1, 0, 2'd0, 16'd2, 5'd2)};
    vecs[8]  = '{0, 0, 0, 0, 32'h0, mk_exp(0, 0, 4'd1, 32'hB2, 0, 0, 1, 2'd1, 16'd3, 5'd2)};
    vecs[9]  = '{0, 0, 0, 0, 32'h0, mk_exp(0, 0, 4'd1, 32'hB2, 0, 0, 1, 2'd1, 16'd3, 5'd2)};
    vecs[10] = '{1, 0, 0, 0, 32'h0, mk_exp(1, 0, 4'd1, 32'hB2, 1, 0, 0, 2'd0, 16'd0, 5'd0)};
    vecs[11] = '{0, 1, 1, 0, 32'hC3, mk_exp(0, 0, 4'd1, 32'hB2, 1, 0, 0, 2'd0, 16'd0, 5'd0)};
    vecs[12] = '{1, 1, 0, 0, 32'h0, mk_exp(0, 0, 4'd1, 32'hB2, 1, 0, 0, 2'd0, 16'd0, 5'd0)};
    vecs[13] = '{0, 0, 1, 0, 32'hD4, mk_exp(0, 0, 4'd1, 32'hB2, 1, 0, 0, 2'd0, 16'd0, 5'd0)};

    tick(2);
    reset = 1'b0;
    checkOutput("reset_state", dut_out(), mk_exp(0, 0, 4'd0, 32'h0, 1, 0, 0, 2'd0, 16'd0, 5'd0));

    // Cycle-by-cycle table: short load, hold, 3-cycle run, restart, abort.
    run_limit = 16'd3;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
    end

    // Asynchronous reset in the middle of a load.
    pulseStart();
    for (int i = 0; i < 3; i++) sendWord(32'h100 + i, 1'b0);
    checkOutput("pre_reset_we", {63'd0, imem_we}, 64'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset", dut_out(), mk_exp(0, 0, 4'd0, 32'h0, 1, 0, 0, 2'd0, 16'd0, 5'd0));
    tick(1);
    reset = 1'b0;
    tick(1);
    checkOutput("after_reset", dut_out(), mk_exp(0, 0, 4'd0, 32'h0, 1, 0, 0, 2'd0, 16'd0, 5'd0));

    // Full program, stop on cycle limit.
    run_limit = 16'd20;
    wr_base = wr_count;
    pulseStart();
    for (int i = 0; i < 6; i++) sendWord(prog[i], i == 5);
    waitDone();
    for (int i = 0; i < 6; i++) checkOutput($sformatf("imem%0d", i), {32'd0, mem[i]}, {32'd0, prog[i]});
    checkOutput("prog_writes", 64'(wr_count - wr_base), 64'd6);
    checkOutput("limit_result", {core_run, core_reset, halt_reason, cycle_count, words_loaded},
                {1'b0, 1'b0, 2'd1, 16'd20, 5'd6});

    // Halt PC 0x18 is the 7th RUN cycle with the PC model.
    halt_en = 1'b1;
    halt_pc = 32'h18;
    pulseStart();
    for (int i = 0; i < 6; i++) sendWord(prog[i], i == 5);
    waitDone();
    checkOutput("halt_pc_result", {core_run, halt_reason, cycle_count}, {1'b0, 2'd2, 16'd7});

    // Halt PC and limit in the same cycle: halt PC wins.
    run_limit = 16'd7;
    pulseStart();
    for (int i = 0; i < 6; i++) sendWord(prog[i], i == 5);
    waitDone();
    checkOutput("priority", {halt_reason, cycle_count}, {2'd2, 16'd7});

    halt_pc = 32'h1C;
    pulseStart();
    for (int i = 0; i < 6; i++) sendWord(prog[i], i == 5);
    waitDone();
    checkOutput("limit_before_pc", {halt_reason, cycle_count}, {2'd1, 16'd7});
    halt_en = 1'b0;

    // Exactly IMEM_DEPTH words with last on the final slot is legal.
    run_limit = 16'd1;
    wr_base = wr_count;
    pulseStart();
    for (int i = 0; i < 16; i++) sendWord(32'h200 + i, i == 15);
    waitDone();
    checkOutput("full_writes", 64'(wr_count - wr_base), 64'd16);
    checkOutput("full_mem15", {32'd0, mem[15]}, 64'h20F);
    checkOutput("full_result", {halt_reason, cycle_count, words_loaded}, {2'd1, 16'd1, 5'd16});

    // 17 words without last: the 17th is dropped and reported as overflow.
    wr_base = wr_count;
    pulseStart();
    for (int i = 0; i < 17; i++) sendWord(32'h300 + i, 1'b0);
    checkOutput("ovf_state", {ld_ready, core_run, done, halt_reason}, {1'b0, 1'b0, 1'b1, 2'd3});
    tick(1);
    checkOutput("ovf_writes", 64'(wr_count - wr_base), 64'd16);
    checkOutput("ovf_mem0", {32'd0, mem[0]}, 64'h300);
    checkOutput("ovf_mem15", {32'd0, mem[15]}, 64'h30F);
    checkOutput("ovf_words", {59'd0, words_loaded}, 64'd16);

    // Gappy valid stream, then abort while running unlimited.
    run_limit = 16'd0;
    wr_base = wr_count;
    pulseStart();
    for (int i = 0; i < 5; i++) begin
      sendWord(32'h400 + i, i == 4);
      tick(1);
    end
    begin
      int guard = 0;
      while (!core_run && guard < 20) begin
        tick(1);
        guard++;
      end
    end
    checkOutput("run_entered", {63'd0, core_run}, 64'd1);
    tick(3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    checkOutput("abort_idle", {ld_ready, imem_we, core_reset, core_run, done}, {5'b00100});
    checkOutput("gap_writes", 64'(wr_count - wr_base), 64'd5);
    for (int i = 0; i < 5; i++) checkOutput($sformatf("gap_mem%0d", i), {32'd0, mem[i]}, 64'(32'h400 + i));
    tick(2);
    checkOutput("abort_stays", {ld_ready, core_reset, core_run, done}, {4'b0100});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
